pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks post-ID stages in a shadow shift register and
// generates stall, bubble, flush, memory-wait and operand forwarding controls.
module pipe_hazard_ctrl #(
    parameter int REG_W  = 4,
    parameter int DEPTH  = 3,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rdm,
    input  logic             id_uses_rn,
    input  logic             id_two_src,
    input  logic             id_wb_en,
    input  logic             id_mem_read,
    input  logic             id_mem_write,
    input  logic [REG_W-1:0] id_dest,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             freeze_if,
    output logic             bubble_ex,
    output logic             flush,
    output logic             mem_stall,
    output logic [1:0]       fwd_sel_rn,
    output logic [1:0]       fwd_sel_rdm,
    output logic [DEPTH-1:0] stage_valid,
    output logic [CNT_W-1:0] stall_count
);

    logic [DEPTH-1:0]            sh_valid, sh_wb, sh_mr, sh_mw;
    logic [DEPTH-1:0][REG_W-1:0] sh_dest;
    logic [DEPTH-1:0]            match_rn, match_rdm;
    logic                        live_rn, live_rdm, hazard, mem_wait, load0;
    logic                        unused_ok;

    assign live_rn  = id_valid & id_uses_rn;
    assign live_rdm = id_valid & id_two_src;

    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign match_rn[i]  = sh_valid[i] & sh_wb[i] & live_rn  & (sh_dest[i] == id_rn);
        assign match_rdm[i] = sh_valid[i] & sh_wb[i] & live_rdm & (sh_dest[i] == id_rdm);
    end

    // With forwarding only a load in EX is unresolvable; otherwise every
    // in-flight writer except WB (which writes before the read) blocks issue.
    if (FWD_EN != 0) begin : g_hz_fwd
        assign hazard = (match_rn[0] | match_rdm[0]) & sh_mr[0];
    end else begin : g_hz_stall
        assign hazard = |(match_rn[DEPTH-2:0] | match_rdm[DEPTH-2:0]);
    end

    assign mem_wait  = sh_valid[1] & (sh_mr[1] | sh_mw[1]) & ~mem_ready;
    assign mem_stall = rst & mem_wait;
    assign flush     = rst & ~mem_wait & branch_taken;
    assign bubble_ex = rst & ~mem_wait & ~branch_taken & hazard;
    assign freeze_if = mem_stall | bubble_ex;

    assign load0       = id_valid & ~branch_taken & ~hazard;
    assign stage_valid = sh_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_valid <= '0;
            sh_wb    <= '0;
            sh_mr    <= '0;
            sh_mw    <= '0;
            sh_dest  <= '0;
        end else if (!mem_wait) begin
            sh_valid <= {sh_valid[DEPTH-2:0], load0};
            sh_wb    <= {sh_wb[DEPTH-2:0], id_wb_en};
            sh_mr    <= {sh_mr[DEPTH-2:0], id_mem_read};
            sh_mw    <= {sh_mw[DEPTH-2:0], id_mem_write};
            sh_dest  <= {sh_dest[DEPTH-2:0], id_dest};
        end
    end

    if (FWD_EN != 0) begin : g_fwd
        logic [1:0] sel_rn_d, sel_rdm_d;
        // EX/MEM result is newer than MEM/WB, so entry 0 wins.
        assign sel_rn_d  = match_rn[0]  ? 2'd1 : (match_rn[1]  ? 2'd2 : 2'd0);
        assign sel_rdm_d = match_rdm[0] ? 2'd1 : (match_rdm[1] ? 2'd2 : 2'd0);

        always_ff @(posedge clk) begin
            if (!rst) begin
                fwd_sel_rn  <= 2'd0;
                fwd_sel_rdm <= 2'd0;
            end else if (!mem_wait) begin
                if (branch_taken || hazard) begin
                    fwd_sel_rn  <= 2'd0;
                    fwd_sel_rdm <= 2'd0;
                end else begin
                    fwd_sel_rn  <= sel_rn_d;
                    fwd_sel_rdm <= sel_rdm_d;
                end
            end
        end
    end else begin : g_nofwd
        assign fwd_sel_rn  = 2'd0;
        assign fwd_sel_rdm = 2'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            stall_count <= '0;
        else if (freeze_if && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end

    // Some shadow bits only matter for certain parameter choices.
    assign unused_ok = ^{sh_mr, sh_mw, match_rn, match_rdm};

endmodule
